pll_lock_sequencer: RTL and testbench

Controller for the CC_PLL instance. Runs on the free-running PLL reference clock, so it never depends on the clock it supervises. It sequences the PLL's lock-steady reset, qualifies lock, and times out and retries failed locks. It drives the reset-release that the design's PLL-clock domain synchronises locally, and it counts loss-of-lock events for debug.

---
 rtl/pll_lock_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset, lock qualification and retry controller for the CC_PLL.
// Runs on the free-running reference clock, so it never depends on the PLL output clock.
// Build option: define PLLSEQ_STDY_LOCK_EN to also require USR_PLL_LOCKED_STDY for lock.
module pll_lock_sequencer #(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 10000,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned LOSS_W        = 8
) (
  input  logic              clock_in,
  input  logic              rst_in,
  input  logic              pll_locked,
  input  logic              pll_locked_stdy,
  input  logic              retry_in,
  output logic              pll_stdy_rst,
  output logic              sys_rst_n,
  output logic              ready,
  output logic              fault,
  output logic [1:0]        attempt,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int unsigned MAX_AB  = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
  // Internal try counter is wide enough for MAX_RETRIES; the attempt port saturates at 3.
  localparam int unsigned TRY_W   = ($clog2(MAX_RETRIES + 1) < 2) ? 2 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT   = TRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StStdyRst,
    StWaitLock,
    StStabilize,
    StRun,
    StFault
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [LOSS_W-1:0]  loss_d;
  logic               lock_s1, lock_s2;
  logic               lock_q;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

`ifdef PLLSEQ_STDY_LOCK_EN
  logic stdy_s1, stdy_s2;

  // Two-flop synchroniser for the lock-steady indication.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      stdy_s1 <= 1'b0;
      stdy_s2 <= 1'b0;
    end else begin
      stdy_s1 <= pll_locked_stdy;
      stdy_s2 <= stdy_s1;
    end
  end

  assign lock_q = lock_s2 & stdy_s2;
`else
  logic unused_stdy;
  assign unused_stdy = pll_locked_stdy;
  assign lock_q      = lock_s2;
`endif

  // Next-state, counter, try and loss-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    loss_d  = loss_count;
    unique case (state_q)
      StStdyRst: begin
        if (cnt_q == RST_LAST) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitLock: begin
        if (lock_q) begin
          // Lock wins over a coincident timeout.
          state_d = StStabilize;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          tries_d = tries_q + TRY_W'(1);
          cnt_d   = '0;
          state_d = (tries_d == TRY_LIMIT) ? StFault : StStdyRst;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStabilize: begin
        if (!lock_q) begin
          // Fresh timeout window, not a failed attempt.
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = StRun;
          cnt_d   = '0;
          tries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        if (!lock_q) begin
          state_d = StStdyRst;
          cnt_d   = '0;
          if (loss_count != '1) begin
            loss_d = loss_count + LOSS_W'(1);
          end
        end
      end
      StFault: begin
        if (retry_in) begin
          state_d = StStdyRst;
          cnt_d   = '0;
          tries_d = '0;
        end
      end
      default: begin
        state_d = StStdyRst;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, and outputs decoded from the next state so they switch with it.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StStdyRst;
      cnt_q        <= '0;
      tries_q      <= '0;
      loss_count   <= '0;
      pll_stdy_rst <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
      attempt      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tries_q      <= tries_d;
      loss_count   <= loss_d;
      pll_stdy_rst <= (state_d == StStdyRst) || (state_d == StFault);
      sys_rst_n    <= (state_d == StRun);
      ready        <= (state_d == StRun);
      fault        <= (state_d == StFault);
      attempt      <= (tries_d > TRY_W'(3)) ? 2'd3 : tries_d[1:0];
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock waveforms,
// checked every cycle against a timestamp-based behavioural model.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int LW = 4;
  localparam int LOSS_MAX = (1 << LW) - 1;

  localparam int PhStdy  = 0;
  localparam int PhWait  = 1;
  localparam int PhStab  = 2;
  localparam int PhRun   = 3;
  localparam int PhFault = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic          locked_stdy = 1'b1;
  logic          retry = 1'b0;
  logic          pll_stdy_rst, sys_rst_n, ready, fault;
  logic [1:0]    attempt;
  logic [LW-1:0] loss_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase plus the absolute edge number at which a timed phase expires.
  int ph, edge_n, deadline, fails, losses;
  bit h1, h2, s1, s2;

  pll_lock_sequencer #(
    .RST_PULSE(RP), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .LOSS_W(LW)
  ) dut (
    .clock_in(clk), .rst_in(rst_n), .pll_locked(locked), .pll_locked_stdy(locked_stdy),
    .retry_in(retry), .pll_stdy_rst(pll_stdy_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .fault(fault), .attempt(attempt), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void enter(int p, int dur);
    ph = p;
    deadline = edge_n + dur;
  endfunction

  function automatic void model_reset();
    edge_n = 0;
    enter(PhStdy, RP);
    fails = 0;
    losses = 0;
    h1 = 0; h2 = 0; s1 = 0; s2 = 0;
  endfunction

  function automatic void model_step();
    bit lk;
    edge_n++;
`ifdef PLLSEQ_STDY_LOCK_EN
    lk = h2 & s2;
`else
    lk = h2;
`endif
    h2 = h1; h1 = locked;
    s2 = s1; s1 = locked_stdy;
    case (ph)
      PhStdy: if (edge_n == deadline) enter(PhWait, LT);
      PhWait: begin
        if (lk) enter(PhStab, SC);
        else if (edge_n == deadline) begin
          fails++;
          if (fails == MR) enter(PhFault, 0);
          else enter(PhStdy, RP);
        end
      end
      PhStab: begin
        if (!lk) enter(PhWait, LT);
        else if (edge_n == deadline) begin
          enter(PhRun, 0);
          fails = 0;
        end
      end
      PhRun: if (!lk) begin
        enter(PhStdy, RP);
        if (losses < LOSS_MAX) losses++;
      end
      default: if (retry) begin
        enter(PhStdy, RP);
        fails = 0;
      end
    endcase
  endfunction

  function automatic logic [9:0] expected();
    logic [1:0]    att;
    logic [LW-1:0] l;
    att = (fails > 3) ? 2'd3 : 2'(fails);
    l = LW'(losses);
    return {ph == PhStdy || ph == PhFault, ph == PhRun, ph == PhRun, ph == PhFault, att, l};
  endfunction

  function automatic logic [9:0] observed();
    return {pll_stdy_rst, sys_rst_n, ready, fault, attempt, loss_count};
  endfunction

  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("model", observed(), expected());
  endtask

  // Assert reset between edges and check outputs before any clock edge arrives.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_val("async_reset", observed(), 10'b10_0000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_ready(input int budget);
    for (int i = 0; i < budget && ready !== 1'b1; i++) cycle();
    check_val("reach_run", {9'd0, ready}, 10'd1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // 1. Clean start.
    apply_reset();
    for (int i = 0; i < 10; i++) cycle();
    locked = 1'b1;
    run_until_ready(30);
    check_val("start_attempt", {8'd0, attempt}, 10'd0);
    check_val("start_srn", {9'd0, sys_rst_n}, 10'd1);

    // 2. Lock glitch during STABILIZE.
    apply_reset();
    for (int i = 0; i < 10; i++) cycle();
    locked = 1'b0;
    cycle();
    locked = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_val("glitch_ready", {9'd0, ready}, 10'd0);
    run_until_ready(40);
    check_val("glitch_attempt", {8'd0, attempt}, 10'd0);

    // 3. Timeouts into FAULT, then retry.
    apply_reset();
    locked = 1'b0;
    for (int i = 0; i < 2 * (RP + LT) + 2; i++) cycle();
    check_val("fault_flag", {9'd0, fault}, 10'd1);
    check_val("fault_attempt", {8'd0, attempt}, 10'd2);
    check_val("fault_stdy", {9'd0, pll_stdy_rst}, 10'd1);
    retry = 1'b1;
    cycle();
    retry = 1'b0;
    check_val("retry_fault", {9'd0, fault}, 10'd0);
    check_val("retry_attempt", {8'd0, attempt}, 10'd0);
    locked = 1'b1;
    run_until_ready(80);

    // 4. Repeated loss of lock in RUN, loss counter saturation.
    apply_reset();
    run_until_ready(40);
    for (int k = 0; k < 16; k++) begin
      locked = 1'b0;
      cycle();
      cycle();
      check_val("loss_pre", {8'd0, ready, sys_rst_n}, 10'b11);
      cycle();
      check_val("loss_edge3", {8'd0, ready, sys_rst_n}, 10'b00);
      locked = 1'b1;
      run_until_ready(40);
    end
    check_val("loss_sat", {6'd0, loss_count}, 10'(LOSS_MAX));

    // 5. Async reset in the middle of STABILIZE.
    for (int i = 0; i < 3; i++) cycle();
    apply_reset();
    for (int i = 0; i < 8; i++) cycle();
    apply_reset();
    run_until_ready(40);

    // 6. Drop only the lock-steady input while in RUN.
    locked_stdy = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
`ifdef PLLSEQ_STDY_LOCK_EN
    check_val("stdy_drop", {9'd0, ready}, 10'd0);
`else
    check_val("stdy_drop", {9'd0, ready}, 10'd1);
`endif
    locked_stdy = 1'b1;
    run_until_ready(40);

    // Random lock / lock-steady / retry waveforms.
    apply_reset();
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      locked = ($urandom_range(0, 3) != 0);
      locked_stdy = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        retry = ($urandom_range(0, 7) == 0);
        cycle();
      end
    end
    retry = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
